vga_scan_engine: RTL and testbench
==================================

VGA_SCAN_ENGINE -- requirements
Module: vga_scan_engine

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 The block SHALL have parameters H_FP/H_SYNC/H_BP, defaults 16/96/48, horizontal porch, sync and back-porch widths in pixels.
REQ-003 The block SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 The block SHALL have parameters V_FP/V_SYNC/V_BP, defaults 10/2/33, vertical porch, sync and back-porch widths in lines.
REQ-005 The block SHALL have parameter CLK_DIV, default 4, system clocks per pixel, legal range 1..16.
REQ-006 The block SHALL have parameter PIPE_DEPTH, default 2, pixel-tick delay of sync/active outputs relative to x/y, legal range 1..8.
REQ-007 The block SHALL have parameters HS_POL/VS_POL, default 0/0, asserted level of hSync/vSync.
REQ-008 The block SHALL have parameter COLOR_BITS, default 12, color bus width.
REQ-009 The block SHALL have port clk, input, 1, the system clock; all logic is clocked on its rising edge.
REQ-010 The block SHALL have port reset, input, 1; reset is synchronous and active-low.
REQ-011 The block SHALL have ports pix_en output 1 (pixel tick); x output clog2(H_TOTAL); y output clog2(V_TOTAL); active_early output 1 (undelayed visible flag).
REQ-012 The block SHALL have ports line_start output 1, frame_start output 1, color_in input COLOR_BITS, hSync output 1, vSync output 1, active output 1, color_out output COLOR_BITS.

Function
REQ-013 H_TOTAL SHALL equal H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL SHALL equal V_ACTIVE+V_FP+V_SYNC+V_BP.
REQ-014 A divider counter SHALL count 0..CLK_DIV-1 and wrap; pix_en SHALL be registered, high for exactly one clk each time the counter equals CLK_DIV-1; with CLK_DIV=1, pix_en SHALL be high every cycle outside reset.
REQ-015 On each clk with pix_en high, x SHALL increment, wrapping H_TOTAL-1 -> 0; on that wrap y SHALL increment, wrapping V_TOTAL-1 -> 0; x/y SHALL hold when pix_en is low.
REQ-016 active_early SHALL be combinational: (x < H_ACTIVE) && (y < V_ACTIVE).
REQ-017 The raw horizontal sync SHALL be at level HS_POL while H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL; the vertical equivalent SHALL use y, V_* and VS_POL.
REQ-018 Raw hsync, vsync and active_early SHALL pass through a PIPE_DEPTH-stage shift register that advances only on pix_en; hSync, vSync and active SHALL be the last stage.
REQ-019 color_out SHALL be combinational: color_in when active is high, zero otherwise.
REQ-020 line_start SHALL pulse one clk when pix_en is high and x = H_TOTAL-1; frame_start SHALL pulse one clk when pix_en is high, x = H_TOTAL-1 and y = V_TOTAL-1.
REQ-021 Parameter combinations outside legal ranges SHALL be rejected at elaboration.

Reset
REQ-022 While reset is low at a clk edge: divider, x, y = 0; pix_en, line_start, frame_start = 0; all pipeline stages = deasserted sync (~POL) and active 0.
REQ-023 Consequently hSync = ~HS_POL, vSync = ~VS_POL, active = 0, color_out = 0 during reset.
REQ-024 Reset asserted mid-frame SHALL take effect at the next clk edge regardless of pix_en; first pix_en after release SHALL occur on the CLK_DIV-th edge.

Configuration
REQ-025 With macro VGA_SCAN_FRAMECNT_EN defined, a 16-bit output frame_count SHALL exist, reset to 0, increment on each frame_start, wrapping 0xFFFF -> 0.
REQ-026 Without VGA_SCAN_FRAMECNT_EN, the frame_count port and its counter SHALL be absent; all other behaviour identical.

Verification (default parameters unless stated)
REQ-027 Release reset -> pix_en first high on edge 4, then every 4 clk; x steps 0,1,2... once per pix_en.
REQ-028 Free run one line -> line_start period 3200 clk; hSync low for 384 consecutive clk, starting 2 pixel ticks after x reaches 656.
REQ-029 Free run two frames -> frame_start period 1,680,000 clk; vSync low for 2 lines (6400 clk); active high for 640x480 ticks per frame.
REQ-030 color_in = 0xABC constant -> color_out = 0xABC only while active, 0x000 in blanking, including the 2 ticks after active_early falls at x = 640.
REQ-031 Assert reset at x=300,y=200 for 1 clk -> next edge x=y=0, hSync=vSync=1, active=0; with VGA_SCAN_FRAMECNT_EN, frame_count returns to 0.
REQ-032 CLK_DIV=1, PIPE_DEPTH=1, HS_POL=1 -> pix_en high every clk after release, hSync high for 96 clk per 800-clk line, 1-tick delay vs raw sync.

Source files
------------

// File: rtl/vga_scan_engine.sv
// VGA raster scan engine: pixel-tick divider, x/y counters, pipelined sync/active and blanked color.
// Optional 16-bit frame counter output when VGA_SCAN_FRAMECNT_EN is defined.
module vga_scan_engine #(
   parameter int unsigned H_ACTIVE   = 640,
   parameter int unsigned H_FP       = 16,
   parameter int unsigned H_SYNC     = 96,
   parameter int unsigned H_BP       = 48,
   parameter int unsigned V_ACTIVE   = 480,
   parameter int unsigned V_FP       = 10,
   parameter int unsigned V_SYNC     = 2,
   parameter int unsigned V_BP       = 33,
   parameter int unsigned CLK_DIV    = 4,
   parameter int unsigned PIPE_DEPTH = 2,
   parameter bit          HS_POL     = 1'b0,
   parameter bit          VS_POL     = 1'b0,
   parameter int unsigned COLOR_BITS = 12
) (
   input  logic                                               clk,
   input  logic                                               reset,
   output logic                                               pix_en,
   output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]       x,
   output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]       y,
   output logic                                               active_early,
   output logic                                               line_start,
   output logic                                               frame_start,
   input  logic [COLOR_BITS-1:0]                              color_in,
   output logic                                               hSync,
   output logic                                               vSync,
   output logic                                               active,
   output logic [COLOR_BITS-1:0]                              color_out
`ifdef VGA_SCAN_FRAMECNT_EN
   ,
   output logic [15:0]                                        frame_count
`endif
);

   localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned XW       = $clog2(H_TOTAL);
   localparam int unsigned YW       = $clog2(V_TOTAL);
   localparam int unsigned DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned HS_START = H_ACTIVE + H_FP;
   localparam int unsigned HS_END   = HS_START + H_SYNC;
   localparam int unsigned VS_START = V_ACTIVE + V_FP;
   localparam int unsigned VS_END   = VS_START + V_SYNC;

   // Elaboration-time rejection of illegal configurations
   if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_clk_div
      $error("vga_scan_engine: CLK_DIV must be in 1..16");
   end
   if (PIPE_DEPTH < 1 || PIPE_DEPTH > 8) begin : g_bad_pipe_depth
      $error("vga_scan_engine: PIPE_DEPTH must be in 1..8");
   end
   if (H_ACTIVE < 1 || V_ACTIVE < 1 || H_TOTAL < 2 || V_TOTAL < 2) begin : g_bad_timing
      $error("vga_scan_engine: active area and totals must be non-degenerate");
   end
   if (COLOR_BITS < 1) begin : g_bad_color
      $error("vga_scan_engine: COLOR_BITS must be at least 1");
   end

   logic [DW-1:0]         div_cnt;
   logic                  line_end_c;
   logic                  frame_end_c;
   logic                  hs_raw_c;
   logic                  vs_raw_c;
   logic [PIPE_DEPTH-1:0] hs_pipe;
   logic [PIPE_DEPTH-1:0] vs_pipe;
   logic [PIPE_DEPTH-1:0] act_pipe;

   assign line_end_c  = pix_en && (32'(x) == H_TOTAL - 1);
   assign frame_end_c = line_end_c && (32'(y) == V_TOTAL - 1);

   // Pixel tick: one clk high when the divider has completed CLK_DIV cycles
   always_ff @(posedge clk) begin
      if (!reset) begin
         div_cnt <= '0;
         pix_en  <= 1'b0;
      end else if (32'(div_cnt) == CLK_DIV - 1) begin
         div_cnt <= '0;
         pix_en  <= 1'b1;
      end else begin
         div_cnt <= div_cnt + DW'(1);
         pix_en  <= 1'b0;
      end
   end

   // Raster position and line/frame boundary pulses
   always_ff @(posedge clk) begin
      if (!reset) begin
         x           <= '0;
         y           <= '0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         line_start  <= line_end_c;
         frame_start <= frame_end_c;
         if (pix_en) begin
            if (line_end_c) begin
               x <= '0;
               y <= (32'(y) == V_TOTAL - 1) ? '0 : y + YW'(1);
            end else begin
               x <= x + XW'(1);
            end
         end
      end
   end

   assign active_early = (32'(x) < H_ACTIVE) && (32'(y) < V_ACTIVE);
   assign hs_raw_c     = (32'(x) >= HS_START && 32'(x) < HS_END) ? HS_POL : ~HS_POL;
   assign vs_raw_c     = (32'(y) >= VS_START && 32'(y) < VS_END) ? VS_POL : ~VS_POL;

   // Delay line aligning sync/active with downstream pixel data
   always_ff @(posedge clk) begin
      if (!reset) begin
         hs_pipe  <= {PIPE_DEPTH{~HS_POL}};
         vs_pipe  <= {PIPE_DEPTH{~VS_POL}};
         act_pipe <= '0;
      end else if (pix_en) begin
         hs_pipe  <= PIPE_DEPTH'({hs_pipe, hs_raw_c});
         vs_pipe  <= PIPE_DEPTH'({vs_pipe, vs_raw_c});
         act_pipe <= PIPE_DEPTH'({act_pipe, active_early});
      end
   end

   assign hSync     = hs_pipe[PIPE_DEPTH-1];
   assign vSync     = vs_pipe[PIPE_DEPTH-1];
   assign active    = act_pipe[PIPE_DEPTH-1];
   assign color_out = active ? color_in : '0;

`ifdef VGA_SCAN_FRAMECNT_EN
   always_ff @(posedge clk) begin
      if (!reset) begin
         frame_count <= '0;
      end else if (frame_start) begin
         frame_count <= frame_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_vga_scan_engine.sv
// Directed bench for vga_scan_engine: default timing, fast-pixel/positive-hsync and a tiny-frame configuration.
module tb_vga_scan_engine;

   logic        clk = 1'b0;
   logic        reset;
   logic [11:0] color_in;
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // default configuration
   logic       d_pe, d_ae, d_ls, d_fs, d_hs, d_vs, d_act;
   logic [9:0] d_x, d_y;
   logic [11:0] d_cout;
`ifdef VGA_SCAN_FRAMECNT_EN
   logic [15:0] d_fcnt;
`endif
   // CLK_DIV=1, PIPE_DEPTH=1, HS_POL=1
   logic       f_pe, f_ae, f_ls, f_fs, f_hs, f_vs, f_act;
   logic [9:0] f_x, f_y;
   logic [11:0] f_cout;
`ifdef VGA_SCAN_FRAMECNT_EN
   logic [15:0] f_fcnt;
`endif
   // 16x8 total frame, CLK_DIV=2, PIPE_DEPTH=3, VS_POL=1
   logic       s_pe, s_ae, s_ls, s_fs, s_hs, s_vs, s_act;
   logic [3:0] s_x;
   logic [2:0] s_y;
   logic [11:0] s_cout;
`ifdef VGA_SCAN_FRAMECNT_EN
   logic [15:0] s_fcnt;
`endif

   vga_scan_engine u_def (
      .clk(clk), .reset(reset), .pix_en(d_pe), .x(d_x), .y(d_y), .active_early(d_ae),
      .line_start(d_ls), .frame_start(d_fs), .color_in(color_in), .hSync(d_hs),
      .vSync(d_vs), .active(d_act), .color_out(d_cout)
`ifdef VGA_SCAN_FRAMECNT_EN
      , .frame_count(d_fcnt)
`endif
   );

   vga_scan_engine #(.CLK_DIV(1), .PIPE_DEPTH(1), .HS_POL(1'b1)) u_fast (
      .clk(clk), .reset(reset), .pix_en(f_pe), .x(f_x), .y(f_y), .active_early(f_ae),
      .line_start(f_ls), .frame_start(f_fs), .color_in(color_in), .hSync(f_hs),
      .vSync(f_vs), .active(f_act), .color_out(f_cout)
`ifdef VGA_SCAN_FRAMECNT_EN
      , .frame_count(f_fcnt)
`endif
   );

   vga_scan_engine #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                     .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                     .CLK_DIV(2), .PIPE_DEPTH(3), .VS_POL(1'b1)) u_small (
      .clk(clk), .reset(reset), .pix_en(s_pe), .x(s_x), .y(s_y), .active_early(s_ae),
      .line_start(s_ls), .frame_start(s_fs), .color_in(color_in), .hSync(s_hs),
      .vSync(s_vs), .active(s_act), .color_out(s_cout)
`ifdef VGA_SCAN_FRAMECNT_EN
      , .frame_count(s_fcnt)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_dx(input int v);
      for (int i = 0; i < 4000 && int'(d_x) != v; i++) tick();
      check("wait_def_x", 32'(d_x), 32'(v));
   endtask

   initial begin
      int n;
      int t0;
      int act_cnt;
      int vs_cnt;

      reset    = 1'b0;
      color_in = 12'hABC;
      repeat (3) tick();
      check("rst_x",      32'(d_x),    0);
      check("rst_y",      32'(d_y),    0);
      check("rst_pe",     32'(d_pe),   0);
      check("rst_hs",     32'(d_hs),   1);
      check("rst_vs",     32'(d_vs),   1);
      check("rst_act",    32'(d_act),  0);
      check("rst_cout",   32'(d_cout), 0);
      check("rst_ls",     32'(d_ls),   0);
      check("rst_fs",     32'(d_fs),   0);
      check("rst_ae",     32'(d_ae),   1);
      check("rst_f_hs",   32'(f_hs),   0);
      check("rst_s_vs",   32'(s_vs),   0);
`ifdef VGA_SCAN_FRAMECNT_EN
      check("rst_fcnt",   32'(d_fcnt), 0);
`endif

      // release: fast pixel ticks every clk, default on the 4th edge
      reset = 1'b1;
      tick();
      check("f_pe_e1", 32'(f_pe), 1);
      check("f_x_e1",  32'(f_x),  0);
      check("d_pe_e1", 32'(d_pe), 0);
      tick();
      check("f_x_e2",  32'(f_x),  1);
      tick();
      check("d_pe_e3", 32'(d_pe), 0);
      tick();
      check("d_pe_e4", 32'(d_pe), 1);
      check("d_x_e4",  32'(d_x),  0);
      tick();
      check("d_pe_e5", 32'(d_pe), 0);
      check("d_x_e5",  32'(d_x),  1);
      repeat (3) tick();
      check("d_pe_e8", 32'(d_pe), 1);
      tick();
      check("d_x_e9",  32'(d_x),  2);

      // fast config: positive hsync, one tick behind raw
      for (int i = 0; i < 1000 && int'(f_x) != 656; i++) tick();
      check("f_x_656",  32'(f_x),  656);
      check("f_hs_656", 32'(f_hs), 0);
      tick();
      check("f_hs_657", 32'(f_hs), 1);
      n = 0;
      while (f_hs === 1'b1 && n < 1000) begin tick(); n++; end
      check("f_hs_width", 32'(n),   96);
      check("f_x_hs_end", 32'(f_x), 753);
      check("f_pe_run",   32'(f_pe), 1);
      for (int i = 0; i < 1000 && f_ls !== 1'b1; i++) tick();
      check("f_ls_x", 32'(f_x), 0);
      t0 = cyc;
      tick();
      for (int i = 0; i < 1000 && f_ls !== 1'b1; i++) tick();
      check("f_ls_period", 32'(cyc - t0), 800);

      // default config: active/color/hsync around end of line 0
      wait_dx(640);
      check("d_ae_640",   32'(d_ae),   0);
      check("d_act_640",  32'(d_act),  1);
      check("d_cout_640", 32'(d_cout), 12'hABC);
      check("d_y_640",    32'(d_y),    0);
      wait_dx(642);
      check("d_act_642",  32'(d_act),  0);
      check("d_cout_642", 32'(d_cout), 0);
      wait_dx(657);
      check("d_hs_657",   32'(d_hs),   1);
      wait_dx(658);
      check("d_hs_658",   32'(d_hs),   0);
      n = 0;
      while (d_hs === 1'b0 && n < 2000) begin tick(); n++; end
      check("d_hs_width", 32'(n),    384);
      check("d_x_hs_end", 32'(d_x),  754);
      check("d_vs_line0", 32'(d_vs), 1);

      for (int i = 0; i < 4000 && d_ls !== 1'b1; i++) tick();
      check("d_ls_x",  32'(d_x),  0);
      check("d_ls_y",  32'(d_y),  1);
      check("d_ls_fs", 32'(d_fs), 0);
      t0 = cyc;
      tick();
      for (int i = 0; i < 4000 && d_ls !== 1'b1; i++) tick();
      check("d_ls_period", 32'(cyc - t0), 3200);
      check("d_ls_y2",     32'(d_y),      2);

      // start of visible line 2 appears two ticks late
      wait_dx(1);
      check("d_act_x1",  32'(d_act),  0);
      check("d_cout_x1", 32'(d_cout), 0);
      wait_dx(2);
      check("d_act_x2",  32'(d_act),  1);
      check("d_cout_x2", 32'(d_cout), 12'hABC);
      color_in = 12'h123;
      #1;
      check("d_cout_pass", 32'(d_cout), 12'h123);
      color_in = 12'hABC;

      // one-clk reset mid-line
      wait_dx(300);
      check("d_y_300", 32'(d_y), 2);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check("mrst_x",    32'(d_x),    0);
      check("mrst_y",    32'(d_y),    0);
      check("mrst_hs",   32'(d_hs),   1);
      check("mrst_vs",   32'(d_vs),   1);
      check("mrst_act",  32'(d_act),  0);
      check("mrst_cout", 32'(d_cout), 0);
      check("mrst_pe",   32'(d_pe),   0);
      check("mrst_s_x",  32'(s_x),    0);
      check("mrst_s_y",  32'(s_y),    0);
`ifdef VGA_SCAN_FRAMECNT_EN
      check("mrst_fcnt", 32'(d_fcnt), 0);
`endif
      repeat (3) tick();
      check("mrst_pe_e3", 32'(d_pe), 0);
      tick();
      check("mrst_pe_e4", 32'(d_pe), 1);

      // tiny frame: 16*8 pixels * 2 clk = 256 clk per frame
      for (int i = 0; i < 1000 && s_fs !== 1'b1; i++) tick();
      check("s_fs_x",  32'(s_x),  0);
      check("s_fs_y",  32'(s_y),  0);
      check("s_fs_ls", 32'(s_ls), 1);
      t0 = cyc;
      act_cnt = 0;
      vs_cnt  = 0;
      n = 0;
      do begin
         if (s_act === 1'b1 && s_pe === 1'b1) act_cnt++;
         if (s_vs === 1'b1) vs_cnt++;
         tick();
         n++;
      end while (s_fs !== 1'b1 && n < 1000);
      check("s_fs_period", 32'(cyc - t0), 256);
      check("s_act_ticks", 32'(act_cnt),  32);
      check("s_vs_clks",   32'(vs_cnt),   64);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
